// File: rtl/seg_scan_pkg.sv
// Shared definitions for the two-digit seven-segment scanner and the octal segment decoder.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment patterns, bit6..bit0 = a..g, active-high.
  localparam logic [6:0] SEG_D0 = 7'b1111110;
  localparam logic [6:0] SEG_D1 = 7'b0110000;
  localparam logic [6:0] SEG_D2 = 7'b1101101;
  localparam logic [6:0] SEG_D3 = 7'b1111001;
  localparam logic [6:0] SEG_D4 = 7'b0110011;
  localparam logic [6:0] SEG_D5 = 7'b1011011;
  localparam logic [6:0] SEG_D6 = 7'b1011111;
  localparam logic [6:0] SEG_D7 = 7'b1110000;

  function automatic int cnt_width(input int div, input int dead);
    int m;
    m = 2;
    if (div > m) m = div;
    if (dead > m) m = dead;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter that times one display slot; tc is high while the count is zero.
module slot_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] count_reg;

  assign tc = (count_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (!tc) begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Two-digit seven-segment scanner with dead-time gaps and frame-aligned capture.
// Define SEG_SCAN_ACTIVE_LOW_EN to invert seg/an at the output registers (common-anode).
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV  = 50000,
  parameter int DEAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] dig0_seg,
  input  logic [6:0] dig1_seg,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int CW = cnt_width(DIV, DEAD);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (DEAD > 0) ? CW'(DEAD - 1) : '0;

`ifdef SEG_SCAN_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_INV = 7'h7F;
  localparam logic [1:0] AN_INV  = 2'b11;
`else
  localparam logic [6:0] SEG_INV = 7'h00;
  localparam logic [1:0] AN_INV  = 2'b00;
`endif

  scan_state_t   state_reg, state_next;
  logic [6:0]    dig0_reg, dig0_next;
  logic [6:0]    dig1_reg, dig1_next;
  logic [6:0]    seg_reg, seg_next;
  logic [1:0]    an_reg, an_next;
  logic          frame_start_reg;
  logic          capture;
  logic          tc;
  logic [CW-1:0] load_val;

  slot_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tc),
    .load_val (load_val),
    .tc       (tc)
  );

  always_comb begin
    state_next = state_reg;
    if (tc) begin
      case (state_reg)
        SHOW0:   state_next = (DEAD > 0) ? GAP0 : SHOW1;
        GAP0:    state_next = SHOW1;
        SHOW1:   state_next = (DEAD > 0) ? GAP1 : SHOW0;
        GAP1:    state_next = SHOW0;
        default: state_next = SHOW0;
      endcase
    end

    // Both digits are captured together on SHOW0 entry so a frame never tears.
    capture   = tc && (state_next == SHOW0);
    dig0_next = capture ? dig0_seg : dig0_reg;
    dig1_next = capture ? dig1_seg : dig1_reg;
    load_val  = ((state_next == SHOW0) || (state_next == SHOW1)) ? SHOW_LOAD : GAP_LOAD;

    seg_next = SEG_BLANK;
    an_next  = 2'b00;
    if (en) begin
      case (state_next)
        SHOW0: begin
          seg_next = dig0_next;
          an_next  = 2'b01;
        end
        SHOW1: begin
          if (dig1_next != SEG_BLANK) begin
            seg_next = dig1_next;
            an_next  = 2'b10;
          end
        end
        default: begin
          seg_next = SEG_BLANK;
          an_next  = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= GAP1;
      dig0_reg        <= SEG_BLANK;
      dig1_reg        <= SEG_BLANK;
      seg_reg         <= SEG_BLANK ^ SEG_INV;
      an_reg          <= 2'b00 ^ AN_INV;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dig0_reg        <= dig0_next;
      dig1_reg        <= dig1_next;
      seg_reg         <= seg_next ^ SEG_INV;
      an_reg          <= an_next ^ AN_INV;
      frame_start_reg <= capture;
    end
  end

  assign seg         = seg_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: DIV=4/DEAD=1 instance plus a DIV=1/DEAD=0 instance.
module tb_seg_scan;
  import seg_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] dig0_seg, dig1_seg;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       fs_a, fs_b;

`ifdef SEG_SCAN_ACTIVE_LOW_EN
  localparam logic [6:0] SI = 7'h7F;
  localparam logic [1:0] AI = 2'b11;
`else
  localparam logic [6:0] SI = 7'h00;
  localparam logic [1:0] AI = 2'b00;
`endif

  localparam logic [9:0] ALL_ON = 10'h3FF;

  seg_scan #(.DIV(4), .DEAD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .dig0_seg(dig0_seg), .dig1_seg(dig1_seg),
    .seg(seg_a), .an(an_a), .frame_start(fs_a)
  );

  seg_scan #(.DIV(1), .DEAD(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .dig0_seg(dig0_seg), .dig1_seg(dig1_seg),
    .seg(seg_b), .an(an_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [6:0] seg;
    logic [1:0] an;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int id, input logic [6:0] s, input logic [1:0] a, input logic f);
    exp_t e;
    e.id  = id;
    e.seg = s ^ SI;
    e.an  = a ^ AI;
    e.fs  = f;
    q.push_back(e);
  endtask

  task automatic step(input int id, input logic [6:0] s, input logic [1:0] a, input logic f);
    @(posedge clk);
    #1;
    push(id, s, a, f);
  endtask

  // One DIV=4/DEAD=1 frame: slots 0-3 digit0, 4 gap, 5-8 digit1, 9 gap.
  task automatic frame(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] mid_d0,
                       input int mid_k, input logic [9:0] en_mask, input int nsteps);
    dig0_seg = d0;
    dig1_seg = d1;
    for (int k = 0; k < nsteps; k++) begin
      logic [6:0] s;
      logic [1:0] a;
      en = en_mask[k];
      if (k == mid_k) dig0_seg = mid_d0;
      if (k < 4) begin
        s = d0; a = 2'b01;
      end else if (k >= 5 && k <= 8 && d1 != SEG_BLANK) begin
        s = d1; a = 2'b10;
      end else begin
        s = SEG_BLANK; a = 2'b00;
      end
      if (!en_mask[k]) begin
        s = SEG_BLANK; a = 2'b00;
      end
      step(0, s, a, k == 0);
    end
  endtask

  exp_t       m_e;
  logic [9:0] m_act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_act = (m_e.id == 0) ? {seg_a, an_a, fs_a} : {seg_b, an_b, fs_b};
      checks++;
      if (m_act !== {m_e.seg, m_e.an, m_e.fs}) begin
        failures++;
        $display("FAIL dut%0d slot t=%0t: got seg=%b an=%b fs=%b, want seg=%b an=%b fs=%b",
                 m_e.id, $time, m_act[9:3], m_act[2:1], m_act[0], m_e.seg, m_e.an, m_e.fs);
      end else if (m_e.fs) begin
        $display("frame dut%0d t=%0t seg=%b an=%b", m_e.id, $time, m_act[9:3], m_act[2:1]);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    dig0_seg = SEG_D2;
    dig1_seg = SEG_D1;
    step(0, SEG_BLANK, 2'b00, 1'b0);
    step(0, SEG_BLANK, 2'b00, 1'b0);
    rst = 1'b0;

    frame(SEG_D2, SEG_D1, SEG_D2, 6, ALL_ON, 10);
    frame(SEG_D2, SEG_D1, SEG_D2, 6, ALL_ON, 10);
    // Blank tens digit.
    frame(SEG_D7, SEG_BLANK, SEG_D7, 6, ALL_ON, 10);
    // Input change during SHOW1 waits for the next frame.
    frame(SEG_D0, SEG_D1, SEG_D4, 6, ALL_ON, 10);
    frame(SEG_D4, SEG_D1, SEG_D4, 6, ALL_ON, 10);
    // Input change during SHOW0 must not tear the displayed digit.
    frame(SEG_D6, SEG_D3, SEG_D5, 2, ALL_ON, 10);
    // en low for 7 cycles across the SHOW0/GAP0/SHOW1 boundaries.
    frame(SEG_D2, SEG_D1, SEG_D2, 6, 10'b1000000011, 10);
    frame(SEG_D2, SEG_D1, SEG_D2, 6, ALL_ON, 10);
    // Reset during SHOW1, then recapture new inputs.
    frame(SEG_D2, SEG_D1, SEG_D2, 6, ALL_ON, 7);
    rst      = 1'b1;
    dig0_seg = SEG_D5;
    dig1_seg = SEG_D6;
    step(0, SEG_BLANK, 2'b00, 1'b0);
    rst = 1'b0;
    frame(SEG_D5, SEG_D6, SEG_D5, 6, ALL_ON, 10);

    // DIV=1, DEAD=0 instance: alternates every cycle, frame every 2 cycles.
    rst      = 1'b1;
    dig0_seg = SEG_D1;
    dig1_seg = SEG_D2;
    step(1, SEG_BLANK, 2'b00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step(1, SEG_D1, 2'b01, 1'b1);
      else            step(1, SEG_D2, 2'b10, 1'b0);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
